// File: rtl/regfile_write_arbiter_if.sv
// Register-file write types and the requester/register-file bus shared by the write arbiter.
// master = requester side, slave = arbiter side.
package regfile_write_arbiter_pkg;
   typedef enum logic [1:0] {
      REG_NOP   = 2'd0,
      REG_WRITE = 2'd1
   } registers_op_e;

   typedef enum logic [1:0] {
      REG_0 = 2'd0,
      REG_1 = 2'd1,
      REG_2 = 2'd2,
      REG_3 = 2'd3
   } register_sel_e;
endpackage

interface regfile_write_arbiter_if #(
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned DATA_BUS_WIDTH = 8
);
   import regfile_write_arbiter_pkg::*;

   logic [NUM_REQ-1:0]                req_valid;
   logic [2*NUM_REQ-1:0]              req_sel;
   logic [DATA_BUS_WIDTH*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]                req_lock;
   logic [NUM_REQ-1:0]                req_ready;
   registers_op_e                     reg_op;
   register_sel_e                     reg_in_sel;
   logic [DATA_BUS_WIDTH-1:0]         reg_data_in;
   logic [3:0]                        reg_pending;

   modport master (
      output req_valid, req_sel, req_data, req_lock,
      input  req_ready, reg_op, reg_in_sel, reg_data_in, reg_pending
   );

   modport slave (
      input  req_valid, req_sel, req_data, req_lock,
      output req_ready, reg_op, reg_in_sel, reg_data_in, reg_pending
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ requesters.
// Define ARB_LOCK_EN to let a requester hold the port for a burst via req_lock.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = 8,
   parameter int unsigned NUM_REQ        = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   regfile_write_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]          ptr;
   logic [PTR_W-1:0]          ptr_nxt;
   logic                      found;
   logic [PTR_W-1:0]          rr_idx;
   logic                      cand;
   logic [PTR_W-1:0]          cand_idx;
   logic                      xfer;
   register_sel_e             cand_sel;
   logic [DATA_BUS_WIDTH-1:0] cand_data;
   int unsigned               idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      found  = 1'b0;
      rr_idx = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            rr_idx = PTR_W'(idx);
         end
      end
   end

`ifdef ARB_LOCK_EN
   logic             lock_vld;
   logic [PTR_W-1:0] lock_id;
   logic             lock_vld_nxt;
   logic [PTR_W-1:0] lock_id_nxt;

   // A lock owner excludes everyone else, even while it is idle.
   always_comb begin
      cand     = lock_vld ? bus.req_valid[lock_id] : found;
      cand_idx = lock_vld ? lock_id : rr_idx;
   end
`else
   logic unused_lock;
   assign unused_lock = ^bus.req_lock;

   always_comb begin
      cand     = found;
      cand_idx = rr_idx;
   end
`endif

   always_comb begin
      xfer          = cand & ~stall & reset;
      bus.req_ready = xfer ? (NUM_REQ'(1) << cand_idx) : '0;
      cand_sel      = register_sel_e'(bus.req_sel[32'(cand_idx) * 2 +: 2]);
      cand_data     = bus.req_data[32'(cand_idx) * DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
   end

   // Pointer and lock-ownership next state.
   always_comb begin
      ptr_nxt = ptr;
      if (xfer) ptr_nxt = ptr_inc(cand_idx);
`ifdef ARB_LOCK_EN
      lock_vld_nxt = lock_vld;
      lock_id_nxt  = lock_id;
      if (lock_vld) begin
         if (!bus.req_lock[lock_id]) begin
            lock_vld_nxt = 1'b0;
            ptr_nxt      = ptr_inc(lock_id);
         end
      end else if (xfer && bus.req_lock[cand_idx]) begin
         lock_vld_nxt = 1'b1;
         lock_id_nxt  = cand_idx;
      end
`endif
   end

   // Staged write towards the register file, one cycle after acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.reg_op      <= REG_NOP;
         bus.reg_in_sel  <= REG_0;
         bus.reg_data_in <= '0;
         bus.reg_pending <= '0;
         ptr             <= '0;
`ifdef ARB_LOCK_EN
         lock_vld        <= 1'b0;
         lock_id         <= '0;
`endif
      end else begin
         if (xfer) begin
            bus.reg_op      <= REG_WRITE;
            bus.reg_in_sel  <= cand_sel;
            bus.reg_data_in <= cand_data;
            bus.reg_pending <= 4'(1) << cand_sel;
         end else begin
            bus.reg_op      <= REG_NOP;
            bus.reg_pending <= '0;
         end
         ptr <= ptr_nxt;
`ifdef ARB_LOCK_EN
         lock_vld <= lock_vld_nxt;
         lock_id  <= lock_id_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a round-robin reference model.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int unsigned N = 3;
   localparam int unsigned W = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic stall = 1'b0;

   always #5 clock = ~clock;

   regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_BUS_WIDTH(W)) bus ();

   regfile_write_arbiter #(.DATA_BUS_WIDTH(W), .NUM_REQ(N)) dut (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   int         m_ptr;
   bit         m_write;
   int         m_sel;
   logic [7:0] m_data;
   logic [3:0] m_pend;
   logic [N-1:0] m_acc;
   logic [7:0] m_rf   [4];
   logic [7:0] dut_rf [4];
`ifdef ARB_LOCK_EN
   bit m_lock_vld;
   int m_lock_id;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] exp_grant();
      if (!reset || stall) return '0;
`ifdef ARB_LOCK_EN
      if (m_lock_vld) return bus.req_valid[m_lock_id] ? N'(1) << m_lock_id : '0;
`endif
      for (int k = 0; k < int'(N); k++) begin
         int i;
         i = (m_ptr + k) % int'(N);
         if (bus.req_valid[i]) return N'(1) << i;
      end
      return '0;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_write = 0;
      m_sel   = 0;
      m_data  = '0;
      m_pend  = '0;
      m_acc   = '0;
`ifdef ARB_LOCK_EN
      m_lock_vld = 0;
      m_lock_id  = 0;
`endif
   endtask

   // Model of one rising edge, using the inputs held during the cycle.
   task automatic model_edge();
      logic [N-1:0] g;
      int win;
      if (!reset) begin
         model_reset();
         return;
      end
      g   = exp_grant();
      win = -1;
      for (int i = 0; i < int'(N); i++) if (g[i]) win = i;
      if (win >= 0) begin
         m_write = 1;
         m_sel   = int'(bus.req_sel[2*win +: 2]);
         m_data  = bus.req_data[W*win +: W];
         m_pend  = 4'(1) << m_sel;
         m_ptr   = (win + 1) % int'(N);
      end else begin
         m_write = 0;
         m_pend  = '0;
      end
`ifdef ARB_LOCK_EN
      if (m_lock_vld) begin
         if (!bus.req_lock[m_lock_id]) begin
            m_lock_vld = 0;
            m_ptr      = (m_lock_id + 1) % int'(N);
         end
      end else if (win >= 0 && bus.req_lock[win]) begin
         m_lock_vld = 1;
         m_lock_id  = win;
      end
`endif
      m_acc = g;
   endtask

   task automatic check_outputs();
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_grant()));
      check_eq("reg_op", 32'(bus.reg_op), m_write ? 32'(REG_WRITE) : 32'(REG_NOP));
      check_eq("reg_in_sel", 32'(bus.reg_in_sel), 32'(m_sel));
      check_eq("reg_data_in", 32'(bus.reg_data_in), 32'(m_data));
      check_eq("reg_pending", 32'(bus.reg_pending), 32'(m_pend));
      if (m_write) m_rf[m_sel] = m_data;
      if (bus.reg_op == REG_WRITE) dut_rf[bus.reg_in_sel] = bus.reg_data_in;
   endtask

   task automatic half_check();
      @(negedge clock);
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic cycle();
      half_check();
      advance();
   endtask

   task automatic set_req(input int i, input bit v, input int sel, input logic [7:0] d, input bit lk);
      bus.req_valid[i]       = v;
      bus.req_sel[2*i +: 2]  = 2'(sel);
      bus.req_data[W*i +: W] = d;
      bus.req_lock[i]        = lk;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      bus.req_valid = '1;
      bus.req_sel   = '0;
      bus.req_data  = '0;
      bus.req_lock  = '0;
      for (int r = 0; r < 4; r++) begin
         m_rf[r]   = '0;
         dut_rf[r] = '0;
      end
      model_reset();

      // Reset held with every requester valid.
      repeat (2) @(negedge clock);
      check_eq("reset_ready", 32'(bus.req_ready), 32'h0);
      check_eq("reset_op", 32'(bus.reg_op), 32'(REG_NOP));
      check_eq("reset_pending", 32'(bus.reg_pending), 32'h0);
      @(posedge clock);
      #1 reset = 1'b1;
      half_check();
      check_eq("first_grant", 32'(bus.req_ready), 32'h1);
      advance();

      // Single write from requester 1.
      bus.req_valid = '0;
      set_req(1, 1, 2, 8'hA5, 0);
      half_check();
      check_eq("single_ready", 32'(bus.req_ready), 32'h2);
      advance();
      bus.req_valid = '0;
      half_check();
      check_eq("single_op", 32'(bus.reg_op), 32'(REG_WRITE));
      check_eq("single_sel", 32'(bus.reg_in_sel), 32'd2);
      check_eq("single_data", 32'(bus.reg_data_in), 32'hA5);
      check_eq("single_pending", 32'(bus.reg_pending), 32'h4);
      advance();
      half_check();
      check_eq("single_rf2", 32'(dut_rf[2]), 32'hA5);
      advance();

      // Full contention for six cycles.
      for (int i = 0; i < int'(N); i++) set_req(i, 1, i, 8'(8'h30 + i), 0);
      repeat (6) cycle();
      bus.req_valid = '0;
      cycle();

      // Two requesters writing the same register in the same cycle.
      do_reset();
      bus.req_valid = '0;
      set_req(0, 1, 3, 8'h11, 0);
      set_req(2, 1, 3, 8'h22, 0);
      half_check();
      check_eq("same_first", 32'(bus.req_ready), 32'h1);
      advance();
      bus.req_valid[0] = 1'b0;
      half_check();
      check_eq("same_second", 32'(bus.reg_data_in), 32'h11);
      check_eq("same_second_ready", 32'(bus.req_ready), 32'h4);
      advance();
      bus.req_valid = '0;
      repeat (2) cycle();
      check_eq("same_rf3", 32'(dut_rf[3]), 32'h22);

      // Stall with a staged write and requests pending.
      set_req(0, 1, 1, 8'h33, 0);
      cycle();
      stall = 1'b1;
      for (int i = 0; i < int'(N); i++) set_req(i, 1, i, 8'(8'h40 + i), 0);
      half_check();
      check_eq("stall_staged_op", 32'(bus.reg_op), 32'(REG_WRITE));
      check_eq("stall_staged_data", 32'(bus.reg_data_in), 32'h33);
      advance();
      repeat (2) begin
         half_check();
         check_eq("stall_ready", 32'(bus.req_ready), 32'h0);
         advance();
      end
      stall = 1'b0;
      half_check();
      check_eq("stall_resume", 32'(bus.req_ready), 32'h2);
      advance();
      bus.req_valid = '0;
      cycle();

      // Requester 1 bursts with req_lock while requester 0 waits.
      do_reset();
      bus.req_valid = '0;
      set_req(0, 1, 0, 8'h44, 0);
      cycle();
      set_req(1, 1, 1, 8'h55, 1);
      for (int k = 0; k < 4; k++) begin
         if (k == 2) bus.req_lock[1] = 1'b0;
         half_check();
`ifdef ARB_LOCK_EN
         check_eq("lock_grant", 32'(bus.req_ready), (k < 3) ? 32'h2 : 32'h1);
`endif
         advance();
      end
      bus.req_valid = '0;
      bus.req_lock  = '0;
      cycle();

      // Reset while a write is staged discards it at once.
      set_req(2, 1, 0, 8'h66, 0);
      cycle();
      reset = 1'b0;
      #1;
      check_eq("midrst_op", 32'(bus.reg_op), 32'(REG_NOP));
      check_eq("midrst_pending", 32'(bus.reg_pending), 32'h0);
      check_eq("midrst_ready", 32'(bus.req_ready), 32'h0);
      model_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      bus.req_valid = '0;
      cycle();

      // Randomized traffic honouring the hold-until-accepted rule.
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (!(bus.req_valid[i] && !m_acc[i]))
               set_req(i, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                       8'($urandom), bus.req_lock[i]);
            bus.req_lock[i] = ($urandom_range(0, 3) != 0);
         end
         stall = ($urandom_range(0, 4) == 0);
         cycle();
      end
      bus.req_valid = '0;
      stall = 1'b0;
      repeat (2) cycle();
      for (int r = 0; r < 4; r++) check_eq("final_rf", 32'(dut_rf[r]), 32'(m_rf[r]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
